sdram_arbiter: RTL

- Shares the single SDRAM controller (req/ack/valid interface, 23-bit word address, 32-bit data) among NUM_PORTS requesters: ROM download writer, CPU program ROM, tile/sprite ROM fetchers.
- Sits between the game core's memory clients and the sdram controller.
- Fixed priority, one transaction in flight.
- Routes the controller's ack and read data back to the port that owns the transaction.

---
 rtl/sdram_arbiter.sv | 107 ++++++++++
 1 files changed

// File: rtl/sdram_arbiter.sv
// Fixed-priority arbiter sharing one SDRAM controller among NUM_PORTS requesters.
// One transaction in flight; ack and read data are routed back to the granted port.
module sdram_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             download,
    input  logic [NUM_PORTS-1:0]             port_req,
    input  logic [NUM_PORTS-1:0]             port_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_data,
    output logic [NUM_PORTS-1:0]             port_ack,
    output logic [NUM_PORTS-1:0]             port_valid,
    output logic [DATA_WIDTH-1:0]            port_q,
    output logic                             sdram_req,
    output logic                             sdram_we,
    output logic [ADDR_WIDTH-1:0]            sdram_addr,
    output logic [DATA_WIDTH-1:0]            sdram_data,
    input  logic                             sdram_ack,
    input  logic                             sdram_valid,
    input  logic [DATA_WIDTH-1:0]            sdram_q
);

    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]           state;
    logic [GW-1:0]        grant;
    logic [NUM_PORTS-1:0] eligible;
    logic [GW-1:0]        pick;
    logic                 any_req;

    // During download only the ROM writer on port 0 may be granted.
    always_comb begin
        eligible = port_req;
        if (download)
            eligible = port_req & NUM_PORTS'(1);
    end

    // Lowest index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        pick    = '0;
        any_req = 1'b0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                pick    = GW'(i);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            grant      <= '0;
            sdram_req  <= 1'b0;
            sdram_we   <= 1'b0;
            sdram_addr <= '0;
            sdram_data <= '0;
            port_ack   <= '0;
            port_valid <= '0;
            port_q     <= '0;
        end else begin
            port_ack   <= '0;
            port_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant      <= pick;
                        sdram_req  <= 1'b1;
                        sdram_we   <= port_we[pick];
                        sdram_addr <= port_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                        sdram_data <= port_data[pick*DATA_WIDTH +: DATA_WIDTH];
                        state      <= REQ;
                    end
                end
                REQ: begin
                    // sdram_valid arriving with the ack is dropped on purpose.
                    if (sdram_ack) begin
                        sdram_req       <= 1'b0;
                        port_ack[grant] <= 1'b1;
                        state           <= sdram_we ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    if (sdram_valid) begin
                        port_q            <= sdram_q;
                        port_valid[grant] <= 1'b1;
                        state             <= DONE;
                    end
                end
                default: begin
                    // Gives the acked requester a cycle to drop port_req.
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
